scpu_decoder_p: RTL and testbench
=================================

// Module: scpu_decoder_p
// PURPOSE
//  Parametrised second-generation decode/control unit of the scpu. Sits between FETCH and EXECUTE.
//  Decodes the IR, sequences each instruction through a 1-3 cycle control FSM and owns the register file.
//  Drives PC/IR/DR load strobes, memory address select, memory write and the ALU op.
//  Optional memory-ready stall.
// PARAMETERS
//  DATA_W   8  datapath width; registers are DATA_W+1 (MSB = carry/sign)
//  REG_NUM  4  number of GPRs, power of 2, >=2; RSEL_W=$clog2(REG_NUM), IR_W=4+2*RSEL_W
// PORTS
//  clk             in   1           clock, rising edge
//  rst_n           in   1           asynchronous reset, active low
//  fetch_ir        in   IR_W        [IR_W-1 -: 4] opcode, then rd_sel, then rs_sel (LSBs)
//  fetch_dr        in   DATA_W      immediate data register
//  fetch_mem_dout  in   DATA_W      memory read data
//  ex_dout         in   DATA_W+1    ALU result
//  mem_ready       in   1           memory ready; present only with SCPU_DEC_STALL_EN
//  dc_load_pc      out  1           PC increment/load strobe
//  dc_load_ir      out  1           IR load; marks the last cycle of the instruction
//  dc_load_dr      out  1           DR load from memory
//  dc_imm          out  1           PC takes the immediate (jump taken)
//  dc_addr_sel     out  2           memory address source = FSM state for memory ops, else 0
//  dc_mem_wr       out  1           memory write strobe
//  dc_op           out  2           ALU op = opcode[1:0]
//  dc_rd, dc_rs    out  DATA_W+1    rd / rs register read data, combinational
// BEHAVIOUR
//  Opcodes: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 LWR, 5 SWR, 6 MOV, 7 NOP,
//           8 JEQ, 9 JNE, A JGT, B JLT, C LWI, D SWI, E LI, F JMP.
//  FSM states C0 -> C1 -> C2 (enc 0, 1, 2); returns to C0 on the last cycle; enc 3 is unreachable and recovers to C0.
//  Instruction length:
//   - NOP: 1 cycle.
//   - ALU ops, LWR, SWR, MOV: 2 cycles.
//   - Jumps, LWI, SWI, LI: 3 cycles.
//  dc_load_ir = 1 in the last cycle. dc_load_pc = dc_load_ir | dc_load_dr.
//  dc_load_dr = 1 in C1 for the 3-cycle class only.
//  dc_mem_wr = 1 in C1 for SWR and in C2 for SWI. dc_imm = jump_en & (state==C2).
//  Jump conditions on dc_rd (N = DATA_W):
//   - JEQ: rd==0.  JNE: rd!=0.  JGT: rd[N]==0 && rd[N-1:0]!=0.  JLT: rd[N]==1.  JMP: always.
//  Register write (to rd):
//   - ALU ops: ex_dout, written in C1.
//   - MOV: rs, written in C1.
//   - LWR: {0, mem_dout}, written in C1.
//   - LI: {0, fetch_dr}, written in C2.
//   - LWI: {0, mem_dout}, written in C2.
//   - All other opcodes leave the register file unchanged (never X).
//  Reads are combinational. A write is visible on dc_rd/dc_rs the cycle after the edge; there is no bypass.
//  Reset (async, any cycle incl. mid-instruction): state=C0, all GPRs=0.
//   - Hence dc_rd=dc_rs=0 and dc_load_dr=dc_mem_wr=dc_imm=0.
//   - dc_load_ir/dc_load_pc = 1 only if the IR holds NOP.
//   - dc_addr_sel=0. dc_op follows the IR.
// CONFIGURATION
//  SCPU_DEC_STALL_EN defined: adds mem_ready. While mem_ready=0:
//   - FSM holds its state.
//   - dc_load_pc/ir/dr, dc_mem_wr and GPR writes are forced to 0.
//   - dc_addr_sel, dc_op, dc_rd, dc_rs and dc_imm are unaffected.
//   - The instruction resumes on the first cycle with mem_ready=1.
//  Not defined: no port; behaves as mem_ready=1.
// STRUCTURE
//  scpu_parameter.h: opcode localparams OP_*, FSM state encodings ST_C0..ST_C2.
//  scpu_define.h: `DLY.
//  Sub-module scpu_regfile: REG_NUM x (DATA_W+1), 1 write / 2 async read ports, async clear on rst_n.
//   - Decoder keeps the FSM, strobe logic and write-data mux.
// TESTING
//  Reset mid-LWI in C1 -> state C0 and R0..R3=0 immediately (async); with IR=0x70, dc_load_ir=dc_load_pc=1 from that cycle.
//  ADD R1,R2 (IR=0x26), ex_dout=0x05A -> C1 asserts load_ir/load_pc, dc_op=2; R1=0x05A after that edge; 2 cycles total.
//  Jumps (3 cycles, dc_load_dr=1 in C1):
//   - JNE R3 (IR=0x9C): R3=0 -> dc_imm=0 in C2; R3=0x101 -> dc_imm=1.
//   - JGT R0=0x100 -> dc_imm=0. JLT R0=0x180 -> dc_imm=1.
//  SWI (IR=0xD4) -> dc_addr_sel 0,1,2 over C0/C1/C2; dc_mem_wr=1 only in C2.
//   - SWR (IR=0x54) -> dc_mem_wr=1 in C1 only.
//  Stall build, LWR R2 (IR=0x48), mem_ready=0 for 3 cycles in C1:
//   - state held; no write, load_ir=0.
//   - R2 = mem_dout on the first ready edge.
//  DATA_W=16, REG_NUM=8 (IR_W=10): MOV R7,R5 (IR=0x1BD) with R5=0x1FFFF -> R7=0x1FFFF after 2 cycles.

Source files
------------

// File: rtl/scpu_decoder_p_pkg.sv
// Shared definitions for the scpu decode/control unit: opcodes, control
// FSM state encodings and the instruction-length helper.
package scpu_decoder_p_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_OR  = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_LWR = 4'h4, OP_SWR = 4'h5, OP_MOV = 4'h6, OP_NOP = 4'h7,
    OP_JEQ = 4'h8, OP_JNE = 4'h9, OP_JGT = 4'hA, OP_JLT = 4'hB,
    OP_LWI = 4'hC, OP_SWI = 4'hD, OP_LI  = 4'hE, OP_JMP = 4'hF
  } opcode_e;

  // ST_BAD is never entered by design; it only exists so recovery is explicit.
  typedef enum logic [1:0] {
    ST_C0  = 2'd0,
    ST_C1  = 2'd1,
    ST_C2  = 2'd2,
    ST_BAD = 2'd3
  } state_e;

  // State in which the instruction finishes: NOP is 1 cycle, the low half of
  // the opcode map takes 2 cycles, the whole upper half (opcode[3]) takes 3.
  function automatic state_e last_state(input opcode_e op);
    if (op == OP_NOP)
      return ST_C0;
    else if (!op[3])
      return ST_C1;
    else
      return ST_C2;
  endfunction

endpackage

// File: rtl/scpu_decoder_p_regfile.sv
// General-purpose register file: REG_NUM x (DATA_W+1) bits, one synchronous
// write port, two combinational read ports, asynchronous clear on rst_n.
module scpu_decoder_p_regfile #(
  parameter int DATA_W  = 8,
  parameter int REG_NUM = 4,
  parameter int RSEL_W  = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [RSEL_W-1:0] waddr_i,
  input  logic [DATA_W:0]   wdata_i,
  input  logic [RSEL_W-1:0] raddr_a_i,
  input  logic [RSEL_W-1:0] raddr_b_i,
  output logic [DATA_W:0]   rdata_a_o,
  output logic [DATA_W:0]   rdata_b_o
);

  logic [DATA_W:0] regs_q [REG_NUM];

  // Register storage: cleared asynchronously, one write per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // No write-to-read bypass: a write shows up the cycle after its edge.
  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/scpu_decoder_p.sv
// scpu decode/control unit. Decodes the IR, steps each instruction through a
// 1-3 cycle control FSM (C0 -> C1 -> C2), drives the fetch/memory strobes and
// owns the register file.
// Optional feature macro SCPU_DEC_STALL_EN: adds mem_ready; while it is low
// the FSM holds and all load/write strobes and register writes are blocked.
module scpu_decoder_p
  import scpu_decoder_p_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int REG_NUM = 4,
  localparam int RSEL_W  = $clog2(REG_NUM),
  localparam int IR_W    = 4 + 2 * RSEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IR_W-1:0]   fetch_ir,
  input  logic [DATA_W-1:0] fetch_dr,
  input  logic [DATA_W-1:0] fetch_mem_dout,
  input  logic [DATA_W:0]   ex_dout,
`ifdef SCPU_DEC_STALL_EN
  input  logic              mem_ready,
`endif
  output logic              dc_load_pc,
  output logic              dc_load_ir,
  output logic              dc_load_dr,
  output logic              dc_imm,
  output logic [1:0]        dc_addr_sel,
  output logic              dc_mem_wr,
  output logic [1:0]        dc_op,
  output logic [DATA_W:0]   dc_rd,
  output logic [DATA_W:0]   dc_rs
);

  opcode_e           opcode;
  logic [RSEL_W-1:0] rd_sel;
  logic [RSEL_W-1:0] rs_sel;
  state_e            state_q, state_d;
  logic              ready;
  logic              is_last;
  logic              jump_en;
  logic              rf_we;
  logic [DATA_W:0]   rf_wdata;

  assign opcode = opcode_e'(fetch_ir[IR_W-1 -: 4]);
  assign rd_sel = fetch_ir[2*RSEL_W-1 -: RSEL_W];
  assign rs_sel = fetch_ir[RSEL_W-1:0];

`ifdef SCPU_DEC_STALL_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  // Control FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_C0;
    else        state_q <= state_d;
  end

  // Next state, strobes, jump decision and register write-data mux.
  always_comb begin
    state_d     = state_q;
    jump_en     = 1'b0;
    rf_we       = 1'b0;
    rf_wdata    = '0;
    is_last     = (state_q == last_state(opcode));
    dc_load_ir  = is_last & ready;
    dc_load_dr  = opcode[3] & (state_q == ST_C1) & ready;
    dc_load_pc  = dc_load_ir | dc_load_dr;
    dc_mem_wr   = ready & (((opcode == OP_SWR) && (state_q == ST_C1)) ||
                           ((opcode == OP_SWI) && (state_q == ST_C2)));
    dc_addr_sel = 2'd0;
    dc_op       = opcode[1:0];

    if (state_q == ST_BAD)
      state_d = ST_C0;
    else if (ready)
      state_d = is_last ? ST_C0 : state_e'(state_q + 2'd1);

    if (opcode inside {OP_LWR, OP_SWR, OP_LWI, OP_SWI})
      dc_addr_sel = state_q;

    case (opcode)
      OP_JEQ: jump_en = (dc_rd == '0);
      OP_JNE: jump_en = (dc_rd != '0);
      OP_JGT: jump_en = !dc_rd[DATA_W] && (dc_rd[DATA_W-1:0] != '0);
      OP_JLT: jump_en = dc_rd[DATA_W];
      OP_JMP: jump_en = 1'b1;
      default: jump_en = 1'b0;
    endcase
    dc_imm = jump_en & (state_q == ST_C2);

    case (opcode)
      OP_AND, OP_OR, OP_ADD, OP_SUB: begin
        rf_we    = (state_q == ST_C1);
        rf_wdata = ex_dout;
      end
      OP_MOV: begin
        rf_we    = (state_q == ST_C1);
        rf_wdata = dc_rs;
      end
      OP_LWR: begin
        rf_we    = (state_q == ST_C1);
        rf_wdata = {1'b0, fetch_mem_dout};
      end
      OP_LI: begin
        rf_we    = (state_q == ST_C2);
        rf_wdata = {1'b0, fetch_dr};
      end
      OP_LWI: begin
        rf_we    = (state_q == ST_C2);
        rf_wdata = {1'b0, fetch_mem_dout};
      end
      default: begin
        rf_we    = 1'b0;
        rf_wdata = '0;
      end
    endcase
    rf_we = rf_we & ready;
  end

  scpu_decoder_p_regfile #(
    .DATA_W (DATA_W),
    .REG_NUM(REG_NUM),
    .RSEL_W (RSEL_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (rf_we),
    .waddr_i  (rd_sel),
    .wdata_i  (rf_wdata),
    .raddr_a_i(rd_sel),
    .raddr_b_i(rs_sel),
    .rdata_a_o(dc_rd),
    .rdata_b_o(dc_rs)
  );

endmodule

// File: tb/tb_scpu_decoder_p.sv
// Bench for scpu_decoder_p: directed instruction scenarios plus randomized
// instruction streams, checked every cycle against an instruction-level model.
module tb_scpu_decoder_p;

  localparam int DW = 8;
  localparam int RN = 4;
  localparam int IW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [IW-1:0] fetch_ir;
  logic [DW-1:0] fetch_dr, mem_dout;
  logic [DW:0]   ex_dout;
  logic          mem_ready;
  logic          dc_load_pc, dc_load_ir, dc_load_dr, dc_imm, dc_mem_wr;
  logic [1:0]    dc_addr_sel, dc_op;
  logic [DW:0]   dc_rd, dc_rs;

  scpu_decoder_p #(.DATA_W(DW), .REG_NUM(RN)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_ir      (fetch_ir),
    .fetch_dr      (fetch_dr),
    .fetch_mem_dout(mem_dout),
    .ex_dout       (ex_dout),
`ifdef SCPU_DEC_STALL_EN
    .mem_ready     (mem_ready),
`endif
    .dc_load_pc    (dc_load_pc),
    .dc_load_ir    (dc_load_ir),
    .dc_load_dr    (dc_load_dr),
    .dc_imm        (dc_imm),
    .dc_addr_sel   (dc_addr_sel),
    .dc_mem_wr     (dc_mem_wr),
    .dc_op         (dc_op),
    .dc_rd         (dc_rd),
    .dc_rs         (dc_rs)
  );

  // Wide configuration: DATA_W=16, REG_NUM=8, IR_W=10.
  logic [9:0]  ir_w;
  logic [15:0] dr_w, md_w;
  logic [16:0] ex_w;
  logic        rdy_w;
  logic        pc_w, ir_ld_w, dr_ld_w, imm_w, wr_w;
  logic [1:0]  addr_w, op_w;
  logic [16:0] rd_w, rs_w;

  scpu_decoder_p #(.DATA_W(16), .REG_NUM(8)) u_dut16 (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_ir      (ir_w),
    .fetch_dr      (dr_w),
    .fetch_mem_dout(md_w),
    .ex_dout       (ex_w),
`ifdef SCPU_DEC_STALL_EN
    .mem_ready     (rdy_w),
`endif
    .dc_load_pc    (pc_w),
    .dc_load_ir    (ir_ld_w),
    .dc_load_dr    (dr_ld_w),
    .dc_imm        (imm_w),
    .dc_addr_sel   (addr_w),
    .dc_mem_wr     (wr_w),
    .dc_op         (op_w),
    .dc_rd         (rd_w),
    .dc_rs         (rs_w)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  logic [DW:0] regs [RN];
  int          cyc;                     // cycles already spent in current instruction

  logic       cap_ir [3], cap_pc [3], cap_dr [3], cap_wr [3], cap_imm [3];
  logic [1:0] cap_addr [3], cap_op [3];

  function automatic int len_of(input int op);
    if (op == 7) return 1;
    if (op < 8)  return 2;
    return 3;
  endfunction

  function automatic bit jump_taken(input int op, input int v);
    case (op)
      8:  return v == 0;
      9:  return v != 0;
      10: return (v > 0) && (v < (1 << DW));
      11: return v >= (1 << DW);
      15: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Called just after a falling edge with inputs settled: checks outputs,
  // then advances the model across the coming rising edge.
  task automatic tick();
    int op, rd, rs, len;
    bit rdy, e_ir, e_dr, e_wr, e_imm;
    int e_addr;
    op  = int'(fetch_ir[7:4]);
    rd  = int'(fetch_ir[3:2]);
    rs  = int'(fetch_ir[1:0]);
    len = len_of(op);
    rdy = mem_ready;
    #1;
    e_ir   = rdy && (cyc == len - 1);
    e_dr   = rdy && (len == 3) && (cyc == 1);
    e_wr   = rdy && (((op == 5) && (cyc == 1)) || ((op == 13) && (cyc == 2)));
    e_addr = (op == 4 || op == 5 || op == 12 || op == 13) ? cyc : 0;
    e_imm  = (cyc == 2) && jump_taken(op, int'(regs[rd]));
    chk("load_ir", dc_load_ir, e_ir);
    chk("load_dr", dc_load_dr, e_dr);
    chk("load_pc", dc_load_pc, e_ir | e_dr);
    chk("mem_wr", dc_mem_wr, e_wr);
    chk("addr_sel", dc_addr_sel, e_addr);
    chk("imm", dc_imm, e_imm);
    chk("op", dc_op, op % 4);
    chk("rd_data", dc_rd, regs[rd]);
    chk("rs_data", dc_rs, regs[rs]);
    if (cyc < 3) begin
      cap_ir[cyc] = dc_load_ir;  cap_pc[cyc] = dc_load_pc;  cap_dr[cyc] = dc_load_dr;
      cap_wr[cyc] = dc_mem_wr;   cap_imm[cyc] = dc_imm;
      cap_addr[cyc] = dc_addr_sel; cap_op[cyc] = dc_op;
    end
    if (rdy) begin
      if (op <= 3 && cyc == 1)       regs[rd] = ex_dout;
      else if (op == 6 && cyc == 1)  regs[rd] = regs[rs];
      else if (op == 4 && cyc == 1)  regs[rd] = {1'b0, mem_dout};
      else if (op == 14 && cyc == 2) regs[rd] = {1'b0, fetch_dr};
      else if (op == 12 && cyc == 2) regs[rd] = {1'b0, mem_dout};
      cyc = (cyc == len - 1) ? 0 : cyc + 1;
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [7:0] ir, input logic [7:0] dr,
                       input logic [7:0] md, input logic [8:0] ex);
    fetch_ir = ir; fetch_dr = dr; mem_dout = md; ex_dout = ex; mem_ready = 1'b1;
    for (int k = 0; k < len_of(int'(ir[7:4])); k++) tick();
  endtask

  task automatic read_reg(input string name, input int idx, input logic [8:0] exp);
    logic [1:0] sel;
    sel = idx[1:0];
    fetch_ir = {4'h7, sel, 2'b00};
    mem_ready = 1'b1;
    #1;
    chk(name, dc_rd, exp);
    tick();
  endtask

  task automatic model_reset();
    for (int i = 0; i < RN; i++) regs[i] = '0;
    cyc = 0;
  endtask

  // Wide-configuration scenario: ADD R5 <- 0x1FFFF, then MOV R7,R5.
  initial begin
    ir_w = 10'h1F8; dr_w = '0; md_w = '0; ex_w = '0; rdy_w = 1'b1;
    @(posedge rst_n);
    @(negedge clk);
    ir_w = 10'h0A8; ex_w = 17'h1FFFF;
    #1 chk("w16_add_c0_ir", ir_ld_w, 1'b0);
    @(negedge clk);
    #1 chk("w16_add_c1_ir", ir_ld_w, 1'b1);
    @(negedge clk);
    ir_w = 10'h1BD;
    #1 chk("w16_mov_c0_ir", ir_ld_w, 1'b0);
    chk("w16_mov_rs", rs_w, 17'h1FFFF);
    @(negedge clk);
    #1 chk("w16_mov_c1_ir", ir_ld_w, 1'b1);
    @(negedge clk);
    ir_w = 10'h1FD;
    #1 chk("w16_r7", rd_w, 17'h1FFFF);
    chk("w16_r5", rs_w, 17'h1FFFF);
  end

  initial begin
    fetch_ir = 8'h70; fetch_dr = '0; mem_dout = '0; ex_dout = '0; mem_ready = 1'b1;
    model_reset();
    #1;
    chk("rst_load_ir_nop", dc_load_ir, 1'b1);
    chk("rst_load_pc_nop", dc_load_pc, 1'b1);
    chk("rst_load_dr", dc_load_dr, 1'b0);
    chk("rst_mem_wr", dc_mem_wr, 1'b0);
    chk("rst_imm", dc_imm, 1'b0);
    chk("rst_addr_sel", dc_addr_sel, 2'd0);
    chk("rst_op_nop", dc_op, 2'd3);
    chk("rst_rd", dc_rd, 9'h0);
    chk("rst_rs", dc_rs, 9'h0);
    fetch_ir = 8'h26;
    #1;
    chk("rst_load_ir_add", dc_load_ir, 1'b0);
    chk("rst_op_add", dc_op, 2'd2);
    fetch_ir = 8'h70;
    @(negedge clk);
    rst_n = 1'b1;

    // ADD R1,R2
    issue(8'h26, 8'h00, 8'h00, 9'h05A);
    chk("add_c0_load_ir", cap_ir[0], 1'b0);
    chk("add_c1_load_ir", cap_ir[1], 1'b1);
    chk("add_c1_load_pc", cap_pc[1], 1'b1);
    chk("add_c1_op", cap_op[1], 2'd2);
    read_reg("add_r1", 1, 9'h05A);

    // JNE R3 with R3=0, then R3=0x101
    issue(8'h9C, 8'h00, 8'h00, 9'h000);
    chk("jne0_c1_load_dr", cap_dr[1], 1'b1);
    chk("jne0_c2_imm", cap_imm[2], 1'b0);
    chk("jne0_c2_load_ir", cap_ir[2], 1'b1);
    issue(8'h2C, 8'h00, 8'h00, 9'h101);
    issue(8'h9C, 8'h00, 8'h00, 9'h000);
    chk("jne1_c2_imm", cap_imm[2], 1'b1);

    // JGT R0=0x100, JLT R0=0x180
    issue(8'h20, 8'h00, 8'h00, 9'h100);
    issue(8'hA0, 8'h00, 8'h00, 9'h000);
    chk("jgt_neg_imm", cap_imm[2], 1'b0);
    issue(8'h20, 8'h00, 8'h00, 9'h180);
    issue(8'hB0, 8'h00, 8'h00, 9'h000);
    chk("jlt_neg_imm", cap_imm[2], 1'b1);

    // SWI / SWR
    issue(8'hD4, 8'h00, 8'h00, 9'h000);
    chk("swi_addr_c0", cap_addr[0], 2'd0);
    chk("swi_addr_c1", cap_addr[1], 2'd1);
    chk("swi_addr_c2", cap_addr[2], 2'd2);
    chk("swi_wr_c1", cap_wr[1], 1'b0);
    chk("swi_wr_c2", cap_wr[2], 1'b1);
    issue(8'h54, 8'h00, 8'h00, 9'h000);
    chk("swr_wr_c0", cap_wr[0], 1'b0);
    chk("swr_wr_c1", cap_wr[1], 1'b1);

    // LI, LWI, MOV
    issue(8'hE8, 8'hA5, 8'h00, 9'h000);
    read_reg("li_r2", 2, 9'h0A5);
    issue(8'hC4, 8'h00, 8'h3C, 9'h000);
    read_reg("lwi_r1", 1, 9'h03C);
    issue(8'h6C, 8'h00, 8'h00, 9'h000);
    read_reg("mov_r3", 3, 9'h180);

`ifdef SCPU_DEC_STALL_EN
    // LWR R2 stalled three cycles in C1
    fetch_ir = 8'h48; mem_dout = 8'h3C; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_load_ir", cap_ir[1], 1'b0);
      chk("stall_addr_sel", cap_addr[1], 2'd1);
    end
    mem_ready = 1'b1;
    tick();
    chk("stall_resume_ir", cap_ir[1], 1'b1);
    read_reg("stall_r2", 2, 9'h03C);
`endif

    // Randomized instruction stream
    for (int n = 0; n < 2000; n++) begin
      if (cyc == 0) fetch_ir = 8'($urandom_range(0, 255));
      fetch_dr = 8'($urandom);
      mem_dout = 8'($urandom);
      ex_dout  = 9'($urandom);
`ifdef SCPU_DEC_STALL_EN
      mem_ready = ($urandom_range(0, 3) != 0);
`else
      mem_ready = 1'b1;
`endif
      tick();
    end
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) if (cyc != 0) tick();
    chk("random_drained", cyc, 0);

    // Asynchronous reset in C1 of LWI, IR switched to NOP
    issue(8'hE4, 8'h77, 8'h00, 9'h000);
    fetch_ir = 8'hC4; mem_dout = 8'h11;
    tick();
    #2;
    fetch_ir = 8'h70;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_load_ir", dc_load_ir, 1'b1);
    chk("midrst_load_pc", dc_load_pc, 1'b1);
    chk("midrst_load_dr", dc_load_dr, 1'b0);
    chk("midrst_addr_sel", dc_addr_sel, 2'd0);
    for (int i = 0; i < 16; i++) begin
      fetch_ir = {4'h7, 4'(i)};
      #1;
      chk("midrst_rd_zero", dc_rd, 9'h0);
      chk("midrst_rs_zero", dc_rs, 9'h0);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    fetch_ir = 8'h70;
    for (int n = 0; n < 60; n++) begin
      if (cyc == 0) fetch_ir = 8'($urandom_range(0, 255));
      fetch_dr = 8'($urandom);
      mem_dout = 8'($urandom);
      ex_dout  = 9'($urandom);
      mem_ready = 1'b1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
